// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-requester round-robin front end for a shared registered ALU stage
module alu_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy,
  output logic             grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_data;
  logic             r_carry, r_id, r_last;
  logic             w_idle, w_any, w_sel, w_done;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  assign w_idle     = r_state == IDLE;
  assign w_any      = req0_valid | req1_valid;
  assign w_sel      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = w_idle && w_any && !w_sel;
  assign req1_ready = w_idle && w_any && w_sel;
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_res      = r_op == 2'b00 ? (r_a & r_b) :
                      r_op == 2'b01 ? (r_a | r_b) :
                      r_op == 2'b10 ? (r_a ^ r_b) : w_sum[WIDTH-1:0];
  assign w_done     = (r_state == RESP) && (r_id ? rsp1_ready : rsp0_ready);
  assign rsp0_valid = (r_state == RESP) && !r_id;
  assign rsp1_valid = (r_state == RESP) && r_id;
  assign rsp_data   = r_data;
  assign rsp_carry  = r_carry;
  assign busy       = !w_idle;
  assign grant_id   = r_id;
  // accept in IDLE, compute in EXEC, hold the result in RESP until the owner takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state <= EXEC;
          r_op    <= w_sel ? req1_op : req0_op;
          r_a     <= w_sel ? req1_a : req0_a;
          r_b     <= w_sel ? req1_b : req0_b;
          r_id    <= w_sel;
        end
        EXEC: begin
          r_data  <= w_res;
          r_carry <= (r_op == 2'b11) && w_sum[WIDTH];
          r_state <= RESP;
        end
        RESP: if (w_done) begin
          r_last  <= r_id;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and randomized checks of alu_rr_arbiter against a behavioural model
module tb_alu_rr_arbiter;
  logic       clk = 0, rst = 1;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_carry, busy, grant_id;
  logic [3:0] rsp_data;
  int         total = 0, bad = 0;
  bit         last = 1;
  logic [4:0] r;
  alu_rr_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (op)
      2'd0: s = int'(a & b);
      2'd1: s = int'(a | b);
      2'd2: s = int'(a ^ b);
      default: s = int'(a) + int'(b);
    endcase
    return 5'(s);
  endfunction
  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk); @(negedge clk);
    rst = 0; last = 1;
  endtask
  task automatic scramble();
    req0_op = 2'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_op = 2'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
  endtask
  // called just after a negedge with the arbiter idle and request inputs already set
  task automatic txn(input bit scr, output logic [4:0] res, output bit w);
    w = (req0_valid && req1_valid) ? ~last : req1_valid;
    res = w ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
    #1;
    chk("req0_ready_idle", req0_ready, !w);
    chk("req1_ready_idle", req1_ready, w);
    @(negedge clk);
    chk("busy_exec", busy, 1);
    chk("grant_id", grant_id, w);
    chk("rsp_valid_exec", {rsp1_valid, rsp0_valid}, 0);
    chk("ready_exec", {req1_ready, req0_ready}, 0);
    if (scr) scramble();
    @(negedge clk);
    chk("rsp_valid_resp", {rsp1_valid, rsp0_valid}, w ? 2'b10 : 2'b01);
    chk("rsp_data", rsp_data, res[3:0]);
    chk("rsp_carry", rsp_carry, res[4]);
    chk("ready_resp", {req1_ready, req0_ready}, 0);
    last = w;
  endtask
  initial begin
    bit w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", {req1_ready, req0_ready}, 0);
      chk("idle_rsp", {rsp1_valid, rsp0_valid}, 0);
      chk("idle_busy", busy, 0);
      chk("idle_data", rsp_data, 0);
      chk("idle_grant", grant_id, 0);
    end
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = 0; req0_a = 4'b1100; req0_b = 4'b1010;
    txn(1, r, w);
    chk("and_result", {r, w}, {5'b01000, 1'b0});
    @(negedge clk);
    chk("idle_after", busy, 0);
    req0_valid = 0; req1_valid = 1; req1_op = 3; req1_a = 4'b1111; req1_b = 4'b0011;
    txn(1, r, w);
    chk("add_result", {r, w}, {5'b10010, 1'b1});
    @(negedge clk);
    req1_op = 2; req1_a = 4'b0110; req1_b = 4'b0101;
    txn(1, r, w);
    chk("xor_result", {r, w}, {5'b00011, 1'b1});
    @(negedge clk);
    req1_valid = 0;
    do_reset();
    req0_valid = 1; req1_valid = 1;
    req0_op = 3; req0_a = 4'd9; req0_b = 4'd8; req1_op = 1; req1_a = 4'b0101; req1_b = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      txn(0, r, w);
      chk("fair_grant", w, i % 2);
      @(negedge clk);
    end
    req1_valid = 0; rsp0_ready = 0; req0_op = 0; req0_a = 4'b0111; req0_b = 4'b1110;
    txn(0, r, w);
    req0_valid = 0; req1_valid = 1; req1_op = 3; req1_a = 4'd3; req1_b = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", {rsp1_valid, rsp0_valid}, 2'b01);
      chk("hold_data", rsp_data, r[3:0]);
      chk("hold_req1_ready", req1_ready, 0);
    end
    rsp0_ready = 1;
    @(negedge clk);
    txn(0, r, w);
    chk("after_hold", {r, w}, {5'b00111, 1'b1});
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_op = 3; req0_a = 4'd5; req0_b = 4'd6;
    #1;
    chk("abort_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0; last = 1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp", {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    chk("abort_rsp_late", {rsp1_valid, rsp0_valid}, 0);
    chk("abort_data", rsp_data, 0);
    req0_valid = 1; req1_valid = 1; req0_op = 1; req1_op = 2;
    txn(0, r, w);
    chk("post_reset_grant", w, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      scramble();
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      if (!req0_valid && !req1_valid) req1_valid = 1;
      txn(1, r, w);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("final_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
